// File: rtl/serial_sub_pkg.sv
// Shared types and the one-bit full-subtractor equation for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {bout, d} for a - b - bin.
    function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
        logic d_s;
        logic bout_s;
        d_s    = a ^ b ^ bin;
        bout_s = (~a & b) | (~(a ^ b) & bin);
        return {bout_s, d_s};
    endfunction

endpackage

// File: rtl/serial_fs_cell.sv
// Combinational one-bit full-subtractor cell, kept as its own instance so
// buffer/splitter insertion can treat it like the adder's gate-level cells.
module serial_fs_cell
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic [1:0] fs_s;

    assign fs_s = fs_bit(a, b, bin);
    assign d    = fs_s[0];
    assign bout = fs_s[1];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) with valid/ready handshakes.
// Optional signed-overflow output ovf_o is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             busy_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             bin_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             d_s;
    logic             bout_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    serial_fs_cell u_fs_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (bin_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Control FSM, operand/result shifting and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            res_sh_r    <= '0;
            bin_r       <= 1'b0;
            diff_r      <= '0;
            borrow_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_r     <= a_i;
                        b_sh_r     <= b_i;
                        res_sh_r   <= '0;
                        bin_r      <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= {d_s, res_sh_r[WIDTH-1:1]};
                    bin_r    <= bout_s;
                    if (cnt_r == LAST_CNT) begin
                        // Counter holds at terminal count; operand bit 0 is now the original MSB.
                        diff_r      <= {d_s, res_sh_r[WIDTH-1:1]};
                        borrow_r    <= bout_s;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r       <= (a_sh_r[0] ^ b_sh_r[0]) & (a_sh_r[0] ^ d_s);
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r       <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy_o    = busy_r;
    assign diff_o    = diff_r;
    assign borrow_o  = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o     = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three instances (WIDTH 8, 2, 64)
// checked against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid [3];
    logic        out_ready[3];
    logic [63:0] a_v      [3];
    logic [63:0] b_v      [3];

    logic        ir8, ov8, bo8, bs8;
    logic        ir2, ov2, bo2, bs2;
    logic        ir64, ov64, bo64, bs64;
    logic [7:0]  d8;
    logic [1:0]  d2;
    logic [63:0] d64;
`ifdef SERIAL_SUB_OVF_EN
    logic        of8, of2, of64;
`endif

    int vectors = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir8),
        .a_i(a_v[0][7:0]), .b_i(b_v[0][7:0]), .out_valid(ov8), .out_ready(out_ready[0]),
        .diff_o(d8), .borrow_o(bo8), .busy_o(bs8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf_o(of8)
`endif
    );

    serial_subtractor #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir2),
        .a_i(a_v[1][1:0]), .b_i(b_v[1][1:0]), .out_valid(ov2), .out_ready(out_ready[1]),
        .diff_o(d2), .borrow_o(bo2), .busy_o(bs2)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf_o(of2)
`endif
    );

    serial_subtractor #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir64),
        .a_i(a_v[2]), .b_i(b_v[2]), .out_valid(ov64), .out_ready(out_ready[2]),
        .diff_o(d64), .borrow_o(bo64), .busy_o(bs64)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf_o(of64)
`endif
    );

    function automatic int wid(input int s);
        case (s)
            0:       return 8;
            1:       return 2;
            default: return 64;
        endcase
    endfunction

    function automatic logic [63:0] g_diff(input int s);
        case (s)
            0:       return {56'd0, d8};
            1:       return {62'd0, d2};
            default: return d64;
        endcase
    endfunction

    function automatic logic g_ir(input int s);
        case (s)
            0:       return ir8;
            1:       return ir2;
            default: return ir64;
        endcase
    endfunction

    function automatic logic g_ov(input int s);
        case (s)
            0:       return ov8;
            1:       return ov2;
            default: return ov64;
        endcase
    endfunction

    function automatic logic g_bo(input int s);
        case (s)
            0:       return bo8;
            1:       return bo2;
            default: return bo64;
        endcase
    endfunction

    function automatic logic g_bs(input int s);
        case (s)
            0:       return bs8;
            1:       return bs2;
            default: return bs64;
        endcase
    endfunction

    // Reference model: plain modular / unsigned / signed arithmetic.
    function automatic logic [63:0] mdl_mask(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (w == 64) ? {64{1'b1}} : ((one << w) - 64'd1);
    endfunction

    function automatic logic [63:0] mdl_diff(input int w, input logic [63:0] a, input logic [63:0] b);
        return (a - b) & mdl_mask(w);
    endfunction

    function automatic logic mdl_borrow(input int w, input logic [63:0] a, input logic [63:0] b);
        return (a & mdl_mask(w)) < (b & mdl_mask(w));
    endfunction

`ifdef SERIAL_SUB_OVF_EN
    function automatic logic g_of(input int s);
        case (s)
            0:       return of8;
            1:       return of2;
            default: return of64;
        endcase
    endfunction

    function automatic logic mdl_ovf(input int w, input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] sa, sb, r, lim, one;
        logic [63:0] am, bm;
        one = 66'sd1;
        am  = a & mdl_mask(w);
        bm  = b & mdl_mask(w);
        sa  = $signed({2'b00, am});
        sb  = $signed({2'b00, bm});
        if (am[w-1]) sa = sa - (one <<< w);
        if (bm[w-1]) sb = sb - (one <<< w);
        r   = sa - sb;
        lim = one <<< (w - 1);
        return (r >= lim) || (r < -lim);
    endfunction
`endif

    // One full transaction on instance s, checked against the model.
    task automatic run_op(input int s, input logic [63:0] a, input logic [63:0] b);
        int          w;
        int          n;
        logic [63:0] ed;
        logic        eb;
        w  = wid(s);
        ed = mdl_diff(w, a, b);
        eb = mdl_borrow(w, a, b);
        n  = 0;
        while (g_ir(s) !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (g_ir(s) !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready w=%0d got %b want 1", w, g_ir(s));
        end
        in_valid[s] = 1'b1; a_v[s] = a; b_v[s] = b;
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
        a_v[s] = {$urandom, $urandom};
        b_v[s] = {$urandom, $urandom};
        vectors++;
        if (g_bs(s) !== 1'b1 || g_ir(s) !== 1'b0) begin
            miscompares++;
            $display("FAIL accept w=%0d busy=%b in_ready=%b want 1/0", w, g_bs(s), g_ir(s));
        end
        n = 0;
        while (g_ov(s) !== 1'b1 && n < w + 10) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (n != w) begin
            miscompares++;
            $display("FAIL latency w=%0d got %0d want %0d", w, n, w);
        end
        vectors++;
        if (g_diff(s) !== ed) begin
            miscompares++;
            $display("FAIL diff w=%0d a=%h b=%h got %h want %h", w, a, b, g_diff(s), ed);
        end
        vectors++;
        if (g_bo(s) !== eb) begin
            miscompares++;
            $display("FAIL borrow w=%0d a=%h b=%h got %b want %b", w, a, b, g_bo(s), eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (g_of(s) !== mdl_ovf(w, a, b)) begin
            miscompares++;
            $display("FAIL ovf w=%0d a=%h b=%h got %b want %b", w, a, b, g_of(s), mdl_ovf(w, a, b));
        end
`endif
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        out_ready[s] = 1'b0;
        vectors++;
        if (g_ov(s) !== 1'b0 || g_ir(s) !== 1'b1 || g_bs(s) !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff w=%0d ov=%b ir=%b busy=%b want 0/1/0", w, g_ov(s), g_ir(s), g_bs(s));
        end
        vectors++;
        if (g_diff(s) !== ed) begin
            miscompares++;
            $display("FAIL diff_hold w=%0d got %h want %h", w, g_diff(s), ed);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (g_ir(i) !== 1'b1 || g_ov(i) !== 1'b0 || g_bs(i) !== 1'b0 ||
                g_diff(i) !== 64'd0 || g_bo(i) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state w=%0d ir=%b ov=%b busy=%b diff=%h borrow=%b",
                         wid(i), g_ir(i), g_ov(i), g_bs(i), g_diff(i), g_bo(i));
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(0, 64'h5A, 64'h23);
        run_op(0, 64'h00, 64'h01);
        run_op(0, 64'h80, 64'h01);
        run_op(0, 64'hFF, 64'hFF);
        run_op(0, 64'h7F, 64'h80);
    endtask

    task automatic test_backpressure();
        int n;
        in_valid[0] = 1'b1; a_v[0] = 64'h5A; b_v[0] = 64'h23;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (ov8 !== 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        in_valid[0] = 1'b1; a_v[0] = 64'h11; b_v[0] = 64'h22;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (d8 !== 8'h37 || ir8 !== 1'b0 || ov8 !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d diff=%h ir=%b ov=%b want 37/0/1", i, d8, ir8, ov8);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        vectors++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release ir=%b ov=%b want 1/0", ir8, ov8);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        vectors++;
        if (ir8 !== 1'b0 || bs8 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept ir=%b busy=%b want 0/1", ir8, bs8);
        end
        n = 0;
        while (ov8 !== 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (n != 8 || d8 !== 8'hEF || bo8 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_result lat=%0d diff=%h borrow=%b want 8/ef/1", n, d8, bo8);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        in_valid[0] = 1'b1; a_v[0] = 64'hFF; b_v[0] = 64'h01;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || bs8 !== 1'b0 || d8 !== 8'h00 || bo8 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset ir=%b ov=%b busy=%b diff=%h borrow=%b", ir8, ov8, bs8, d8, bo8);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 64'h10, 64'h20);
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            b = (i % 6 == 0) ? a : {$urandom, $urandom};
            run_op(1, a, b);
            run_op(2, a, b);
            run_op(0, a, b);
        end
        run_op(2, 64'd0, {64{1'b1}});
        run_op(2, 64'h8000_0000_0000_0000, 64'd1);
        run_op(1, 64'd0, 64'd3);
        run_op(1, 64'd2, 64'd1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
